// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in/serial-out shift register with valid/ready on both sides.
// Ports: clk, rst_n (async active-low); load_valid/load_ready/load_data (parallel word in);
// ser_valid/ser_ready/ser_out/ser_last (serial bit out); busy (word in flight).
// Define PISO_MSB_FIRST_EN to emit MSB first; default build emits LSB first.
module piso_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic ld, sh;
`ifdef PISO_MSB_FIRST_EN
  assign sr_shift = {sr_q[WIDTH-2:0], 1'b0};
  assign ser_out  = sr_q[WIDTH-1];
`else
  assign sr_shift = {1'b0, sr_q[WIDTH-1:1]};
  assign ser_out  = sr_q[0];
`endif
  // sr and rem are cleared in IDLE, so ser_out and ser_last need no state gating
  assign ser_valid  = state_q == SHIFT;
  assign ser_last   = rem_q == CNT_W'(1);
  assign busy       = ser_valid;
  assign sh         = ser_valid && ser_ready;
  assign load_ready = state_q == IDLE || (sh && ser_last);
  assign ld         = load_valid && load_ready;
  always_comb begin
    state_d = ld ? SHIFT : (sh && ser_last) ? IDLE : state_q;
    sr_d    = ld ? load_data : (sh && ser_last) ? '0 : sh ? sr_shift : sr_q;
    rem_d   = ld ? CNT_W'(WIDTH) : sh ? rem_q - 1'b1 : rem_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
    end
endmodule
